// File: rtl/pipeline_stall_controller_if.sv
// Handshake bundle between the stall controller and the hazard unit, mul/div unit and
// pipeline registers. The controller drives the pipeline controls through the master modport.
interface pipeline_stall_controller_if;
    logic load_use;
    logic mc_req;
    logic mc_done;
    logic branch_taken;
    logic pc_write;
    logic ifid_write;
    logic idex_bubble;
    logic ifid_flush;
    logic idex_flush;
    logic mc_start;
    logic mc_abort;

    modport master (
        input  load_use, mc_req, mc_done, branch_taken,
        output pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, mc_start, mc_abort
    );

    modport slave (
        output load_use, mc_req, mc_done, branch_taken,
        input  pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, mc_start, mc_abort
    );
endinterface

// File: rtl/pipeline_stall_controller.sv
// Stall/flush sequencer for the 5-stage RV32 pipeline: merges load-use, multi-cycle mul/div
// and taken-branch events into PC / IF/ID / ID/EX controls with Mealy outputs.
module pipeline_stall_controller #(
    parameter int MC_TIMEOUT = 64,
    parameter int CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    pipeline_stall_controller_if.master  ctl,
    output logic [CNT_W-1:0]             stall_cycles,
    output logic                         timeout_err
);

    localparam int TMR_W = $clog2(MC_TIMEOUT) + 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MC_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_MC_WAIT,
        ST_TRAP
    } state_t;

    state_t           state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             timeout_set;

    logic pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, mc_start, mc_abort;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        timeout_set = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        mc_start    = 1'b0;
        mc_abort    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (ctl.branch_taken) begin
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                end else if (ctl.load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                end else if (ctl.mc_req) begin
                    mc_start    = 1'b1;
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    timer_d     = TMR_W'(1);
                    state_d     = ST_MC_WAIT;
                end
            end

            ST_MC_WAIT: begin
                if (ctl.branch_taken) begin
                    // The held mul/div op is on the wrong path: cancel it along with the flush.
                    mc_abort   = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    timer_d    = '0;
                    state_d    = ST_RUN;
                end else if (ctl.mc_done) begin
                    timer_d = '0;
                    state_d = ST_RUN;
                end else if (timer_q == TMR_LAST) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    mc_abort    = 1'b1;
                    timeout_set = 1'b1;
                    state_d     = ST_TRAP;
                end else begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    timer_d     = timer_q + TMR_W'(1);
                end
            end

            default: begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        endcase

        // Reset holds the front end frozen immediately, without waiting for a clock edge.
        if (!rst_n) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b0;
            idex_flush  = 1'b0;
            mc_start    = 1'b0;
            mc_abort    = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            timer_q      <= '0;
            stall_cycles <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            if (timeout_set) begin
                timeout_err <= 1'b1;
            end
            if (!pc_write && (stall_cycles != {CNT_W{1'b1}})) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
        end
    end

    assign ctl.pc_write    = pc_write;
    assign ctl.ifid_write  = ifid_write;
    assign ctl.idex_bubble = idex_bubble;
    assign ctl.ifid_flush  = ifid_flush;
    assign ctl.idex_flush  = idex_flush;
    assign ctl.mc_start    = mc_start;
    assign ctl.mc_abort    = mc_abort;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Directed bench for pipeline_stall_controller: reset, load-use, mul/div wait, branch priority,
// abort, timeout trap, counter saturation and async reset, with hand-computed expectations.
module tb_pipeline_stall_controller;

    localparam int MC_TIMEOUT = 8;
    localparam int CNT_W      = 4;

    // {pc_write, ifid_write, idex_bubble, ifid_flush, idex_flush, mc_start, mc_abort}
    localparam logic [6:0] O_DEF   = 7'b1100000;
    localparam logic [6:0] O_STALL = 7'b0010000;
    localparam logic [6:0] O_FLUSH = 7'b1101100;
    localparam logic [6:0] O_START = 7'b0010010;
    localparam logic [6:0] O_BRABT = 7'b1101101;
    localparam logic [6:0] O_TOABT = 7'b0010001;

    logic             clk;
    logic             rst_n;
    logic [CNT_W-1:0] stall_cycles;
    logic             timeout_err;
    logic [6:0]       outs;
    int               checks;
    int               errors;

    pipeline_stall_controller_if bus ();

    pipeline_stall_controller #(
        .MC_TIMEOUT (MC_TIMEOUT),
        .CNT_W      (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctl          (bus.master),
        .stall_cycles (stall_cycles),
        .timeout_err  (timeout_err)
    );

    assign outs = {bus.pc_write, bus.ifid_write, bus.idex_bubble, bus.ifid_flush,
                   bus.idex_flush, bus.mc_start, bus.mc_abort};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog sim time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic lu, input logic mr, input logic md, input logic bt);
        bus.load_use     = lu;
        bus.mc_req       = mr;
        bus.mc_done      = md;
        bus.branch_taken = bt;
    endtask

    task automatic apply_reset();
        drive(0, 0, 0, 0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== O_STALL) begin errors++; $display("FAIL reset_outs got=%b exp=%b", outs, O_STALL); end
        @(posedge clk);
        #1;
        checks++;
        if (stall_cycles !== 4'd0 || timeout_err !== 1'b0) begin
            errors++; $display("FAIL reset_state got cnt=%0d err=%b exp cnt=0 err=0", stall_cycles, timeout_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #1;
        checks++;
        if (outs !== O_DEF) begin errors++; $display("FAIL reset_release got=%b exp=%b", outs, O_DEF); end
    endtask

    task automatic test_load_use();
        apply_reset();
        drive(1, 0, 0, 0);
        #1;
        checks++;
        if (outs !== O_STALL) begin errors++; $display("FAIL lu_stall got=%b exp=%b", outs, O_STALL); end
        tick();
        drive(0, 0, 0, 0);
        #1;
        checks++;
        if (outs !== O_DEF) begin errors++; $display("FAIL lu_after got=%b exp=%b", outs, O_DEF); end
        checks++;
        if (stall_cycles !== 4'd1) begin errors++; $display("FAIL lu_count got=%0d exp=1", stall_cycles); end
    endtask

    task automatic test_mc_done();
        apply_reset();
        drive(0, 1, 0, 0);
        #1;
        checks++;
        if (outs !== O_START) begin errors++; $display("FAIL mc_start got=%b exp=%b", outs, O_START); end
        tick();
        for (int i = 1; i <= 4; i++) begin
            #1;
            checks++;
            if (outs !== O_STALL) begin errors++; $display("FAIL mc_hold%0d got=%b exp=%b", i, outs, O_STALL); end
            tick();
        end
        drive(0, 1, 1, 0);
        #1;
        checks++;
        if (outs !== O_DEF) begin errors++; $display("FAIL mc_release got=%b exp=%b", outs, O_DEF); end
        tick();
        drive(0, 0, 0, 0);
        #1;
        checks++;
        if (outs !== O_DEF || stall_cycles !== 4'd5) begin
            errors++; $display("FAIL mc_after got=%b cnt=%0d exp=%b cnt=5", outs, stall_cycles, O_DEF);
        end
        drive(0, 0, 1, 0);
        #1;
        checks++;
        if (outs !== O_DEF) begin errors++; $display("FAIL mc_done_in_run got=%b exp=%b", outs, O_DEF); end
        tick();
        drive(0, 0, 0, 0);
        #1;
        checks++;
        if (outs !== O_DEF || stall_cycles !== 4'd5) begin
            errors++; $display("FAIL mc_done_in_run_after got=%b cnt=%0d exp=%b cnt=5", outs, stall_cycles, O_DEF);
        end
    endtask

    task automatic test_branch_priority();
        apply_reset();
        drive(1, 1, 0, 1);
        #1;
        checks++;
        if (outs !== O_FLUSH) begin errors++; $display("FAIL br_prio got=%b exp=%b", outs, O_FLUSH); end
        tick();
        drive(0, 0, 0, 0);
        #1;
        checks++;
        if (outs !== O_DEF || stall_cycles !== 4'd0) begin
            errors++; $display("FAIL br_stay_run got=%b cnt=%0d exp=%b cnt=0", outs, stall_cycles, O_DEF);
        end
    endtask

    task automatic test_branch_abort();
        apply_reset();
        drive(0, 1, 0, 0);
        #1;
        checks++;
        if (outs !== O_START) begin errors++; $display("FAIL ab_start got=%b exp=%b", outs, O_START); end
        tick();
        for (int i = 1; i <= 2; i++) begin
            #1;
            checks++;
            if (outs !== O_STALL) begin errors++; $display("FAIL ab_wait%0d got=%b exp=%b", i, outs, O_STALL); end
            tick();
        end
        drive(0, 1, 0, 1);
        #1;
        checks++;
        if (outs !== O_BRABT) begin errors++; $display("FAIL ab_abort got=%b exp=%b", outs, O_BRABT); end
        tick();
        drive(0, 0, 1, 0);
        #1;
        checks++;
        if (outs !== O_DEF) begin errors++; $display("FAIL ab_late_done got=%b exp=%b", outs, O_DEF); end
        tick();
        drive(0, 0, 0, 0);
        #1;
        checks++;
        if (outs !== O_DEF || stall_cycles !== 4'd3) begin
            errors++; $display("FAIL ab_after got=%b cnt=%0d exp=%b cnt=3", outs, stall_cycles, O_DEF);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        drive(0, 1, 0, 0);
        #1;
        checks++;
        if (outs !== O_START) begin errors++; $display("FAIL to_start got=%b exp=%b", outs, O_START); end
        tick();
        drive(0, 0, 0, 0);
        for (int i = 1; i <= 6; i++) begin
            #1;
            checks++;
            if (outs !== O_STALL) begin errors++; $display("FAIL to_wait%0d got=%b exp=%b", i, outs, O_STALL); end
            tick();
        end
        #1;
        checks++;
        if (outs !== O_TOABT || timeout_err !== 1'b0) begin
            errors++; $display("FAIL to_abort got=%b err=%b exp=%b err=0", outs, timeout_err, O_TOABT);
        end
        tick();
        #1;
        checks++;
        if (timeout_err !== 1'b1 || stall_cycles !== 4'd8 || outs !== O_STALL) begin
            errors++; $display("FAIL to_trap got err=%b cnt=%0d outs=%b exp err=1 cnt=8 outs=%b",
                               timeout_err, stall_cycles, outs, O_STALL);
        end
        drive(1, 1, 1, 1);
        #1;
        checks++;
        if (outs !== O_STALL) begin errors++; $display("FAIL to_trap_ignore got=%b exp=%b", outs, O_STALL); end
        tick();
        checks++;
        if (stall_cycles !== 4'd9 || timeout_err !== 1'b1) begin
            errors++; $display("FAIL to_trap_persist got cnt=%0d err=%b exp cnt=9 err=1", stall_cycles, timeout_err);
        end
        drive(0, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== O_STALL || timeout_err !== 1'b0 || stall_cycles !== 4'd0) begin
            errors++; $display("FAIL to_reset got outs=%b err=%b cnt=%0d exp outs=%b err=0 cnt=0",
                               outs, timeout_err, stall_cycles, O_STALL);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #1;
        checks++;
        if (outs !== O_DEF) begin errors++; $display("FAIL to_reset_run got=%b exp=%b", outs, O_DEF); end
    endtask

    task automatic test_saturation();
        apply_reset();
        drive(1, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick();
        drive(0, 0, 0, 0);
        #1;
        checks++;
        if (stall_cycles !== 4'd15 || outs !== O_DEF) begin
            errors++; $display("FAIL sat_count got cnt=%0d outs=%b exp cnt=15 outs=%b", stall_cycles, outs, O_DEF);
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        drive(0, 1, 0, 0);
        tick();
        drive(0, 0, 0, 0);
        tick();
        drive(0, 0, 1, 0);
        #1;
        checks++;
        if (outs !== O_DEF) begin errors++; $display("FAIL ar_release_seen got=%b exp=%b", outs, O_DEF); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (outs !== O_STALL || stall_cycles !== 4'd0) begin
            errors++; $display("FAIL ar_forced got outs=%b cnt=%0d exp outs=%b cnt=0", outs, stall_cycles, O_STALL);
        end
        drive(0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #1;
        checks++;
        if (outs !== O_DEF) begin errors++; $display("FAIL ar_run_no_abort got=%b exp=%b", outs, O_DEF); end
        tick();
        #1;
        checks++;
        if (outs !== O_DEF || stall_cycles !== 4'd0) begin
            errors++; $display("FAIL ar_run_hold got outs=%b cnt=%0d exp outs=%b cnt=0", outs, stall_cycles, O_DEF);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(0, 0, 0, 0);
        test_reset();
        test_load_use();
        test_mc_done();
        test_branch_priority();
        test_branch_abort();
        test_timeout();
        test_saturation();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
